mem_bridge_rx: RTL and testbench
================================

MEM_BRIDGE_RX -- requirements
Module: mem_bridge_rx

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 4: number of address bytes per command, little-endian, range 1..4.
REQ-002 SHALL have parameter DATA_BYTES, default 4: number of bytes per data word, little-endian, range 1..4.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum allowed gap between bytes within one command, in clk_in cycles.
REQ-004 SHALL have port clk_in, input, 1: the single clock.
REQ-005 SHALL have port rst_in, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port data_in, input, 8: received UART byte.
REQ-007 SHALL have port valid_in, input, 1: data_in is valid this cycle (single-cycle strobe).
REQ-008 SHALL have port addr_out, output, 8*ADDR_BYTES: word address of the memory request.
REQ-009 SHALL have port data_out, output, 8*DATA_BYTES: write data.
REQ-010 SHALL have port we_out, output, 1: the request is a write.
REQ-011 SHALL have port re_out, output, 1: the request is a read.
REQ-012 SHALL have port valid_out, output, 1: request pending.
REQ-013 SHALL have port ready_in, input, 1: memory side accepts the request.
REQ-014 SHALL have port err_out, output, 1: one-cycle error pulse.
REQ-015 SHALL have port busy_out, output, 1: a command is in progress (state is not IDLE).

Function
REQ-016 SHALL implement states IDLE, ADDR, LEN, DATA, CSUM (only when REQ-030 applies), plus a pending-request flag.
REQ-017 SHALL act on command bytes only in IDLE:
- "W" (0x57): single write.
- "R" (0x52): single read.
- "B" (0x42): burst write.
- Any other byte in IDLE is ignored silently.
REQ-018 SHALL move IDLE -> ADDR on a command byte, then collect ADDR_BYTES bytes, first byte into bits [7:0].
REQ-019 "R" SHALL issue the request (re_out=1, we_out=0) after the last address byte, then return to IDLE.
REQ-020 "W" SHALL move ADDR -> DATA, collect DATA_BYTES bytes, issue the request (we_out=1) and return to IDLE.
REQ-021 "B" SHALL move ADDR -> LEN, read one count byte N, then receive N+1 words:
- Word k goes to addr+k; the address wraps modulo 2^(8*ADDR_BYTES).
- Return to IDLE after word N.
REQ-022 valid_out SHALL assert in the cycle after the final byte of a request is accepted.
- addr_out, data_out, we_out and re_out SHALL be held stable while valid_out=1 and ready_in=0.
REQ-023 The handshake SHALL complete on a cycle with valid_out=1 and ready_in=1; valid_out deasserts the next cycle unless a new request is issued in that same cycle (back-to-back allowed).
REQ-024 During a burst, the next word SHALL assemble in a separate buffer while a request is pending.
- If that word completes while the previous request is still unacknowledged: drop it, pulse err_out, abort to IDLE.
- The pending request SHALL remain valid.
REQ-025 The byte-gap counter SHALL reset on every valid_in.
- When busy and the counter reaches TIMEOUT_CYCLES: pulse err_out, discard the partial command, go to IDLE.
- valid_in and timeout in the same cycle: the byte wins, no timeout.
REQ-026 err_out SHALL be low except for single-cycle pulses defined in REQ-024, REQ-025 and REQ-031.

Reset
REQ-027 On rst_in, asynchronously:
- addr_out, data_out, we_out, re_out, valid_out, err_out and busy_out all go to 0.
- State goes to IDLE; all counters and buffers clear.
REQ-028 Reset mid-command or with a request pending SHALL discard it with no request issued; the first byte after release is parsed in IDLE.

Configuration
REQ-029 The feature SHALL be controlled by macro MEM_BRIDGE_RX_CSUM_EN.
REQ-030 With MEM_BRIDGE_RX_CSUM_EN defined:
- Every single command, and every burst word, is followed by one checksum byte in state CSUM.
- The checksum is the XOR of all bytes since the command byte (burst: since the command byte for word 0, since the previous checksum for later words).
- A request is issued only if the checksum matches.
REQ-031 With MEM_BRIDGE_RX_CSUM_EN defined, a checksum mismatch SHALL drop the request, pulse err_out and return to IDLE.
REQ-032 Without MEM_BRIDGE_RX_CSUM_EN, the CSUM state and checksum logic SHALL be absent and the framing SHALL have no checksum bytes.

Structure
REQ-033 Package mem_bridge_pkg SHALL hold:
- the state enum;
- command constants CMD_WRITE, CMD_READ, CMD_BURST.
REQ-034 The byte-gap timeout SHALL be a sub-module byte_gap_timer with parameter TIMEOUT_CYCLES, inputs clear and enable, and a one-cycle expired output.

Verification
REQ-035 "W" 10 00 02 00 EF BE AD DE, ready_in=1 -> one valid_out cycle with addr_out=0x00020010, data_out=0xDEADBEEF, we_out=1.
REQ-036 "R" 04 00 00 00, ready_in held 0 for 5 cycles -> valid_out, addr_out=0x4 and re_out=1 stable for 5 cycles; deassert 1 cycle after ready_in=1.
REQ-037 "B" FF FF FF FF 01 then words 0x11111111 and 0x22222222 -> requests at addr 0xFFFFFFFF then 0x00000000.
REQ-038 "W" plus 3 bytes, then TIMEOUT_CYCLES idle cycles -> err_out pulses, busy_out=0, no request; a following "R" is parsed normally.
REQ-039 rst_in asserted after 6 bytes of a "W" -> all outputs 0 immediately; no request issued after release.
REQ-040 With MEM_BRIDGE_RX_CSUM_EN: "R" 00 00 00 00 52 -> request issued; same with checksum 53 -> err_out pulse, no request.

Source files
------------

// File: rtl/mem_bridge_rx_pkg.sv
// mem_bridge_pkg: shared types and constants for the UART memory-bridge receiver.
// Holds the parser state enum, the command byte values and a command-byte test.
// MEM_BRIDGE_RX_CSUM_EN adds the CSUM state used by the checksum framing.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3
`ifdef MEM_BRIDGE_RX_CSUM_EN
    , CSUM = 3'd4
`endif
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // "W"
  localparam logic [7:0] CMD_READ  = 8'h52;  // "R"
  localparam logic [7:0] CMD_BURST = 8'h42;  // "B"

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ) || (b == CMD_BURST);
  endfunction

endpackage

// File: rtl/mem_bridge_rx_timer.sv
// byte_gap_timer: counts idle cycles between received bytes of one command.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th idle cycle.
// Backpressure: none; clear (a byte this cycle) always beats expiry.
// Ports: clk_in/rst_in clock and async active-high reset; clear restarts the
//   count; enable arms the timer; expired is a one-cycle pulse.
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // r_cnt holds (idle cycles so far - 1) during the current idle cycle, so the
  // compare against TIMEOUT_CYCLES-1 fires on the TIMEOUT_CYCLES-th idle cycle.
  assign expired = enable && !clear && (r_cnt == LIMIT);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt <= '0;
    end else if (!enable || clear || expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bridge_rx.sv
// mem_bridge_rx: parses UART command bytes ("W" write, "R" read, "B" burst
//   write) into little-endian memory requests with a valid/ready handshake.
// Latency: valid_out rises the cycle after the final byte of a request.
// Backpressure: one request is held stable until ready_in; a request completing
//   while another is still unacknowledged is dropped, err_out pulses, parser idles.
// Config: define MEM_BRIDGE_RX_CSUM_EN to append an XOR checksum byte per request.
// Ports: clk_in, rst_in (async, active-high); data_in/valid_in byte strobe;
//   addr_out/data_out/we_out/re_out/valid_out request, ready_in accept;
//   err_out one-cycle error pulse; busy_out a command is being parsed.
module mem_bridge_rx
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_BYTES     = 4,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [7:0]              data_in,
  input  logic                    valid_in,
  output logic [8*ADDR_BYTES-1:0] addr_out,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    we_out,
  output logic                    re_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    err_out,
  output logic                    busy_out
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam logic [1:0] A_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] D_LAST = 2'(DATA_BYTES - 1);

  // parser state and assembly buffers
  state_t        r_state, w_state_nxt;
  logic [7:0]    r_cmd,   w_cmd_nxt;
  logic [AW-1:0] r_abuf,  w_abuf_nxt;
  logic [DW-1:0] r_dbuf,  w_dbuf_nxt;
  logic [1:0]    r_bcnt,  w_bcnt_nxt;
  logic [7:0]    r_len,   w_len_nxt;
  logic [7:0]    r_widx,  w_widx_nxt;
`ifdef MEM_BRIDGE_RX_CSUM_EN
  logic [7:0]    r_csum,  w_csum_nxt;
`endif

  // request output registers
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_we;
  logic          r_re;
  logic          r_valid;
  logic          r_err;

  logic          w_issue;
  logic          w_load;
  logic          w_fail;
  logic          w_tmo;
  logic          w_busy;
  logic [AW-1:0] w_req_addr;
  logic [DW-1:0] w_req_data;

  assign w_busy    = (r_state != IDLE);
  assign busy_out  = w_busy;
  assign addr_out  = r_addr;
  assign data_out  = r_data;
  assign we_out    = r_we;
  assign re_out    = r_re;
  assign valid_out = r_valid;
  assign err_out   = r_err;

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (valid_in),
    .enable (w_busy),
    .expired(w_tmo)
  );

  // Burst word k targets base+k; the base stays in r_abuf and wraps naturally.
  // The _nxt buffers are used so a request can issue on its own final byte.
  assign w_req_addr = w_abuf_nxt + AW'(r_widx);
  assign w_req_data = (r_cmd == CMD_READ) ? '0 : w_dbuf_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_abuf_nxt  = r_abuf;
    w_dbuf_nxt  = r_dbuf;
    w_bcnt_nxt  = r_bcnt;
    w_len_nxt   = r_len;
    w_widx_nxt  = r_widx;
    w_issue     = 1'b0;
    w_fail      = 1'b0;
    w_load      = 1'b0;
`ifdef MEM_BRIDGE_RX_CSUM_EN
    w_csum_nxt  = r_csum;
`endif

    if (valid_in) begin
`ifdef MEM_BRIDGE_RX_CSUM_EN
      w_csum_nxt = r_csum ^ data_in;
`endif
      case (r_state)
        IDLE: begin
          if (is_cmd(data_in)) begin
            w_cmd_nxt   = data_in;
            w_state_nxt = ADDR;
            w_bcnt_nxt  = '0;
            w_widx_nxt  = '0;
`ifdef MEM_BRIDGE_RX_CSUM_EN
            // checksum covers the command byte itself
            w_csum_nxt  = data_in;
`endif
          end
        end
        ADDR: begin
          for (int i = 0; i < ADDR_BYTES; i++) begin
            if (r_bcnt == 2'(i)) w_abuf_nxt[8*i +: 8] = data_in;
          end
          if (r_bcnt == A_LAST) begin
            w_bcnt_nxt = '0;
            if (r_cmd == CMD_READ) begin
`ifdef MEM_BRIDGE_RX_CSUM_EN
              w_state_nxt = CSUM;
`else
              w_issue = 1'b1;
`endif
            end else if (r_cmd == CMD_WRITE) begin
              w_state_nxt = DATA;
            end else begin
              w_state_nxt = LEN;
            end
          end else begin
            w_bcnt_nxt = r_bcnt + 2'd1;
          end
        end
        LEN: begin
          w_len_nxt   = data_in;
          w_bcnt_nxt  = '0;
          w_state_nxt = DATA;
        end
        DATA: begin
          for (int i = 0; i < DATA_BYTES; i++) begin
            if (r_bcnt == 2'(i)) w_dbuf_nxt[8*i +: 8] = data_in;
          end
          if (r_bcnt == D_LAST) begin
            w_bcnt_nxt = '0;
`ifdef MEM_BRIDGE_RX_CSUM_EN
            w_state_nxt = CSUM;
`else
            w_issue = 1'b1;
`endif
          end else begin
            w_bcnt_nxt = r_bcnt + 2'd1;
          end
        end
`ifdef MEM_BRIDGE_RX_CSUM_EN
        CSUM: begin
          // next burst word checksums from a clean accumulator
          w_csum_nxt = '0;
          if (data_in == r_csum) w_issue = 1'b1;
          else                   w_fail  = 1'b1;
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_tmo) begin
      w_fail = 1'b1;
    end

    // The output slot is free if empty or being accepted this very cycle.
    w_load = w_issue && (!r_valid || ready_in);
    if (w_issue && !w_load) w_fail = 1'b1;

    if (w_load && (r_cmd == CMD_BURST) && (r_widx != r_len)) begin
      w_state_nxt = DATA;
      w_widx_nxt  = r_widx + 8'd1;
    end else if (w_issue) begin
      w_state_nxt = IDLE;
    end

    if (w_fail) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_abuf  <= '0;
      r_dbuf  <= '0;
      r_bcnt  <= '0;
      r_len   <= '0;
      r_widx  <= '0;
`ifdef MEM_BRIDGE_RX_CSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_abuf  <= w_abuf_nxt;
      r_dbuf  <= w_dbuf_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_len   <= w_len_nxt;
      r_widx  <= w_widx_nxt;
`ifdef MEM_BRIDGE_RX_CSUM_EN
      r_csum  <= w_csum_nxt;
`endif
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_fail;
      if (w_load) begin
        r_addr  <= w_req_addr;
        r_data  <= w_req_data;
        r_we    <= (r_cmd != CMD_READ);
        r_re    <= (r_cmd == CMD_READ);
        r_valid <= 1'b1;
      end else if (ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bridge_rx.sv
// tb_mem_bridge_rx: randomized command streams checked against a byte-framing
//   reference model; directed cases for hold, wrap, timeout, overflow, reset.
module tb_mem_bridge_rx;
  import mem_bridge_pkg::*;

  localparam int T = 20;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic        we_out, re_out, valid_out, err_out, busy_out;

  always #5 clk_in = ~clk_in;

  mem_bridge_rx #(
    .ADDR_BYTES(4),
    .DATA_BYTES(4),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (data_in),
    .valid_in (valid_in),
    .addr_out (addr_out),
    .data_out (data_out),
    .we_out   (we_out),
    .re_out   (re_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .err_out  (err_out),
    .busy_out (busy_out)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        re;
  } req_t;

  req_t       obs_q[$];
  req_t       exp_q[$];
  req_t       cand_q[$];
  logic [7:0] frame[$];
  int         wend[$];
  logic [31:0] wbuf[$];
  int         err_seen = 0;
  int         vld_cycles = 0;
  int         err_base = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  // monitor: sampled mid-cycle, well away from the active edge
  always @(negedge clk_in) begin
    req_t m;
    if (valid_out === 1'b1 && ready_in === 1'b1) begin
      m = {addr_out, data_out, we_out, re_out};
      obs_q.push_back(m);
    end
    if (err_out === 1'b1) err_seen++;
    if (valid_out === 1'b1) vld_cycles++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      valid_in = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    tick();
    data_in  = b;
    valid_in = 1'b1;
    repeat (gap) begin
      tick();
      valid_in = 1'b0;
    end
  endtask

  task automatic send_frame(input int nbytes);
    for (int j = 0; j < nbytes; j++) send_byte(frame[j], 0);
  endtask

  // Builds the byte stream for one command and the request each word yields.
  // bad >= 0 corrupts that word's checksum; the frame stops after it.
  task automatic mk_frame(input logic [7:0] cmd, input logic [31:0] addr,
                          input int nw, input int bad);
    logic [7:0] cs;
    req_t       r;
    frame.delete();
    wend.delete();
    cand_q.delete();
    cs = cmd;
    frame.push_back(cmd);
    for (int i = 0; i < 4; i++) begin
      frame.push_back(addr[8*i +: 8]);
      cs ^= addr[8*i +: 8];
    end
    if (cmd == CMD_READ) begin
`ifdef MEM_BRIDGE_RX_CSUM_EN
      frame.push_back((bad == 0) ? (cs ^ 8'h01) : cs);
`endif
      wend.push_back(frame.size() - 1);
      r = {addr, 32'h0, 1'b0, 1'b1};
      cand_q.push_back(r);
    end else begin
      if (cmd == CMD_BURST) begin
        frame.push_back(8'(nw - 1));
        cs ^= 8'(nw - 1);
      end
      for (int k = 0; k < nw; k++) begin
        for (int i = 0; i < 4; i++) begin
          frame.push_back(wbuf[k][8*i +: 8]);
          cs ^= wbuf[k][8*i +: 8];
        end
`ifdef MEM_BRIDGE_RX_CSUM_EN
        frame.push_back((k == bad) ? (cs ^ 8'h01) : cs);
        cs = 8'h00;
`endif
        wend.push_back(frame.size() - 1);
        r = {addr + 32'(k), wbuf[k], 1'b1, 1'b0};
        cand_q.push_back(r);
        if (k == bad) break;
      end
    end
  endtask

  task automatic cmp_reqs(input string tag, input int exp_err);
    chk({tag, "_nreq"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_addr"}, obs_q[i].a, exp_q[i].a);
      chk({tag, "_we"}, obs_q[i].we, exp_q[i].we);
      chk({tag, "_re"}, obs_q[i].re, exp_q[i].re);
      if (exp_q[i].we) chk({tag, "_data"}, obs_q[i].d, exp_q[i].d);
    end
    chk({tag, "_err"}, err_seen - err_base, exp_err);
    chk({tag, "_busy"}, busy_out, 1'b0);
    obs_q.delete();
    exp_q.delete();
    err_base = err_seen;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int vld_base;
    rst_in   = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    ready_in = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("rst_addr", addr_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_we", we_out, 0);
    chk("rst_re", re_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_busy", busy_out, 0);
    tick();
    rst_in = 1'b0;
    idle(2);
    err_base = err_seen;

    // single write, immediate accept, exactly one valid cycle
    wbuf = '{32'hDEADBEEF};
    mk_frame(CMD_WRITE, 32'h0002_0010, 1, -1);
    exp_q = cand_q;
    vld_base = vld_cycles;
    send_frame(frame.size());
    idle(4);
    chk("w_vcycles", vld_cycles - vld_base, 1);
    cmp_reqs("w", 0);

    // read held under backpressure for 5 cycles
    ready_in = 1'b0;
    mk_frame(CMD_READ, 32'h4, 1, -1);
    exp_q = cand_q;
    send_frame(frame.size());
    for (int c = 0; c < 5; c++) begin
      tick();
      valid_in = 1'b0;
      chk("hold_valid", valid_out, 1);
      chk("hold_addr", addr_out, 32'h4);
      chk("hold_re", re_out, 1);
      chk("hold_we", we_out, 0);
    end
    ready_in = 1'b1;
    tick();
    chk("hold_drop", valid_out, 0);
    idle(3);
    cmp_reqs("hold", 0);

    // burst wrapping past the top of the address space
    wbuf = '{32'h11111111, 32'h22222222};
    mk_frame(CMD_BURST, 32'hFFFF_FFFF, 2, -1);
    exp_q = cand_q;
    send_frame(frame.size());
    idle(4);
    cmp_reqs("wrap", 0);

    // burst word completing while the previous request is still pending
    ready_in = 1'b0;
    wbuf = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    mk_frame(CMD_BURST, 32'h100, 2, -1);
    exp_q.push_back(cand_q[0]);
    send_frame(frame.size());
    idle(3);
    chk("ovf_valid", valid_out, 1);
    chk("ovf_addr", addr_out, 32'h100);
    chk("ovf_data", data_out, 32'hA5A5A5A5);
    ready_in = 1'b1;
    idle(3);
    cmp_reqs("ovf", 1);

    // gap of T-1 idle cycles inside a command is tolerated
    wbuf = '{32'hCAFE0001};
    mk_frame(CMD_WRITE, 32'h20, 1, -1);
    exp_q = cand_q;
    for (int j = 0; j < frame.size(); j++) send_byte(frame[j], (j == 3) ? T - 1 : 0);
    idle(4);
    cmp_reqs("gap_ok", 0);

    // "W" + 3 bytes then T idle cycles: timeout, then a read parses normally
    wbuf = '{32'h0BADF00D};
    mk_frame(CMD_WRITE, 32'h1234, 1, -1);
    send_frame(4);
    idle(T);
    chk("tmo_early", err_seen - err_base, 0);
    idle(2);
    cmp_reqs("tmo", 1);
    mk_frame(CMD_READ, 32'h8, 1, -1);
    exp_q = cand_q;
    send_frame(frame.size());
    idle(4);
    cmp_reqs("tmo_next", 0);

    // reset during a write with a read still pending
    ready_in = 1'b0;
    mk_frame(CMD_READ, 32'h77, 1, -1);
    send_frame(frame.size());
    idle(2);
    wbuf = '{32'hA1B2C3D4};
    mk_frame(CMD_WRITE, 32'h55667788, 1, -1);
    send_frame(6);
    tick();
    valid_in = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("arst_addr", addr_out, 0);
    chk("arst_data", data_out, 0);
    chk("arst_we", we_out, 0);
    chk("arst_re", re_out, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_err", err_out, 0);
    chk("arst_busy", busy_out, 0);
    tick();
    tick();
    rst_in = 1'b0;
    for (int j = 6; j < frame.size(); j++) send_byte(frame[j], 0);
    ready_in = 1'b1;
    idle(4);
    cmp_reqs("arst", 0);
    mk_frame(CMD_READ, 32'hC, 1, -1);
    exp_q = cand_q;
    send_frame(frame.size());
    idle(4);
    cmp_reqs("arst_next", 0);

`ifdef MEM_BRIDGE_RX_CSUM_EN
    mk_frame(CMD_READ, 32'h0, 1, -1);
    exp_q = cand_q;
    send_frame(frame.size());
    idle(4);
    cmp_reqs("csum_ok", 0);
    mk_frame(CMD_READ, 32'h0, 1, 0);
    send_frame(frame.size());
    idle(4);
    cmp_reqs("csum_bad", 1);
`endif

    // randomized commands: gaps, timeouts, bad checksums, stray bytes
    for (int it = 0; it < 40; it++) begin
      int         sel, nw, mode, bad, p, g, exp_err;
      logic [7:0] cmd, junk;
      logic [31:0] a;
      sel = $urandom_range(0, 2);
      cmd = (sel == 0) ? CMD_WRITE : (sel == 1) ? CMD_READ : CMD_BURST;
      nw  = (cmd == CMD_BURST) ? $urandom_range(1, 4) : 1;
      a   = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFE;
      wbuf.delete();
      for (int k = 0; k < nw; k++) wbuf.push_back($urandom);
      mode = $urandom_range(0, 3);
      bad  = -1;
`ifdef MEM_BRIDGE_RX_CSUM_EN
      if (mode == 3) bad = $urandom_range(0, nw - 1);
`endif
      mk_frame(cmd, a, nw, bad);
      p = frame.size() - 1;
      if (mode == 2) p = $urandom_range(0, frame.size() - 2);
      for (int k = 0; k < cand_q.size(); k++)
        if (wend[k] <= p && k != bad) exp_q.push_back(cand_q[k]);
      for (int j = 0; j <= p; j++) begin
        if (j == p) g = (mode == 2) ? T + $urandom_range(0, 3) : 0;
        else        g = ($urandom_range(0, 7) == 0) ? T - 1 : $urandom_range(0, 2);
        send_byte(frame[j], g);
      end
      idle(4);
      exp_err = (mode == 2 || bad >= 0) ? 1 : 0;
      cmp_reqs("rnd", exp_err);
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        if (is_cmd(junk)) junk ^= 8'h80;
        send_byte(junk, 0);
        idle(3);
        cmp_reqs("junk", 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
